// File: rtl/clockworks_divider.sv
// clockworks_divider: divides the board clock CLK by 2^(SLOW+1) to give the
// slow core clock clk, and generates an active-low core reset resetn that
// is released RST_HOLD slow-clock rising edges after RESET deasserts.
//
// Optional build macro CLOCKWORKS_BYPASS_EN: removes the divider, passes
// CLK straight through to clk, and counts the reset hold in CLK edges.
module clockworks_divider #(
  parameter int SLOW     = 21,
  parameter int RST_HOLD = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  // Power-up values match the reset values so nothing starts as X on FPGA.
  logic [7:0] hold   = 8'(RST_HOLD);
  logic       resetn_q = 1'b0;
  logic       rise;

`ifdef CLOCKWORKS_BYPASS_EN

  // Fast build: no division, every CLK edge counts as a slow-clock edge.
  assign clk  = CLK;
  assign rise = 1'b1;

`else

  logic [SLOW:0] cnt      = '0;
  logic [SLOW:0] cnt_nxt;
  logic          clk_prev = 1'b0;

  assign cnt_nxt = cnt + (SLOW+1)'(1);

  // rise flags the edge at which cnt[SLOW] is about to go 0->1, so the hold
  // counter steps on the same CLK edge that raises clk.
  assign rise = cnt_nxt[SLOW] & ~clk_prev;

  // Free-running divider counter plus the registered previous slow-clock bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      clk_prev <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      clk_prev <= cnt_nxt[SLOW];
    end
  end

  // clk is taken straight from a register bit: no glitch path.
  assign clk = cnt[SLOW];

`endif

  // Reset hold counter; resetn goes high on the edge after hold hits zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold     <= 8'(RST_HOLD);
      resetn_q <= 1'b0;
    end else begin
      if (rise && (hold != 8'd0))
        hold <= hold - 8'd1;
      resetn_q <= (hold == 8'd0);
    end
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clockworks_divider.sv
// Bench for clockworks_divider: three instances with different SLOW/RST_HOLD
// share CLK and RESET; expected outputs come from a closed-form model of the
// release sequence and are queued per step, then popped after the edge.
module tb_clockworks_divider;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  logic clk_a, rstn_a, clk_b, rstn_b, clk_c, rstn_c;

  clockworks_divider #(.SLOW(2), .RST_HOLD(4)) u_a (
    .CLK(CLK), .RESET(RESET), .clk(clk_a), .resetn(rstn_a));
  clockworks_divider #(.SLOW(0), .RST_HOLD(1)) u_b (
    .CLK(CLK), .RESET(RESET), .clk(clk_b), .resetn(rstn_b));
  clockworks_divider #(.SLOW(3), .RST_HOLD(2)) u_c (
    .CLK(CLK), .RESET(RESET), .clk(clk_c), .resetn(rstn_c));

  always #5 CLK = ~CLK;

  typedef struct {
    int   n;
    logic clk_a, rstn_a, clk_b, rstn_b, clk_c, rstn_c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;   // non-reset CLK edges since the last reset edge

  // Expected clk, sampled 1 time unit after a CLK rising edge.
  function automatic logic model_clk(int s, int nn);
`ifdef CLOCKWORKS_BYPASS_EN
    return 1'b1;
`else
    return 1'(((nn % (1 << (s + 1))) >> s) & 1);
`endif
  endfunction

  // Expected resetn: high once more edges have passed than the h-th rise.
  function automatic logic model_rstn(int s, int h, int nn);
`ifdef CLOCKWORKS_BYPASS_EN
    return nn > h;
`else
    int last_rise;
    last_rise = (1 << s) + (h - 1) * (1 << (s + 1));
    return nn > last_rise;
`endif
  endfunction

  task automatic check(input string tag, input int nn, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, nn, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    exp_t e, g;
    int   nn;
    @(negedge CLK);
    RESET = r;
    nn = r ? 0 : n + 1;
    e.n      = nn;
    e.clk_a  = model_clk(2, nn);
    e.rstn_a = model_rstn(2, 4, nn);
    e.clk_b  = model_clk(0, nn);
    e.rstn_b = model_rstn(0, 1, nn);
    e.clk_c  = model_clk(3, nn);
    e.rstn_c = model_rstn(3, 2, nn);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    check("a_clk",  g.n, clk_a,  g.clk_a);
    check("a_rstn", g.n, rstn_a, g.rstn_a);
    check("b_clk",  g.n, clk_b,  g.clk_b);
    check("b_rstn", g.n, rstn_b, g.rstn_b);
    check("c_clk",  g.n, clk_c,  g.clk_c);
    check("c_rstn", g.n, rstn_c, g.rstn_c);
    n = nn;
  endtask

  initial begin
    // Reset for 3 cycles, then a long run: >=5 periods of u_a, u_c wraps 3x,
    // all resetn releases observed.
    repeat (3) step(1'b1);
    repeat (60) step(1'b0);

    // Advance until u_a's clk is high, then a single-cycle reset mid-run.
    for (int k = 0; k < 8 && (n % 8) != 5; k++) step(1'b0);
    step(1'b1);

    // Full sequence again, then resetn held high for well over 100 cycles.
    repeat (140) step(1'b0);

    // RESET held several cycles; sequence restarts from first low edge.
    repeat (5) step(1'b1);
    repeat (40) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
